// File: rtl/ndarray_row_serializer.sv
// Captures one ROWS x COLS frame per handshake and streams it out one row per
// transfer in ascending row order, optionally skipping all-zero rows.
module ndarray_row_serializer #(
  parameter int ROWS      = 6,
  parameter int COLS      = 3,
  parameter int ELEM_W    = 2,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic                              CLK,
  input  logic                              ASYNCRESETN,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ROWS*COLS*ELEM_W-1:0]       in_frame,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLS*ELEM_W-1:0]            out_row,
  output logic [$clog2(ROWS)-1:0]           out_idx,
  output logic                              out_last,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int IDX_W   = $clog2(ROWS);
  localparam int ROW_W   = COLS * ELEM_W;
  localparam int FRAME_W = ROWS * ROW_W;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [ROWS-1:0]      mask_q,  mask_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic                 done_q,  done_d;

  logic [ROWS-1:0]      in_mask;
  logic [ROWS-1:0]      above_mask;
  logic                 is_last;

  // Rows eligible for emission: every row, or only the non-zero ones.
  function automatic logic [ROWS-1:0] send_mask(input logic [FRAME_W-1:0] f);
    logic [ROWS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      m[r] = SKIP_ZERO ? (|f[r*ROW_W +: ROW_W]) : 1'b1;
    end
    return m;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [ROWS-1:0] m);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (m[r]) res = IDX_W'(r);
    end
    return res;
  endfunction

  always_comb begin
    in_mask = send_mask(in_frame);
    for (int r = 0; r < ROWS; r++) begin
      above_mask[r] = mask_q[r] && (IDX_W'(r) > idx_q);
    end
    is_last = ~|above_mask;
  end

  // NOTE: every signal driven here gets its default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (|in_mask) begin
            frame_d = in_frame;
            mask_d  = in_mask;
            idx_d   = lowest_set(in_mask);
            state_d = ST_EMIT;
          end else begin
            // Nothing to send; keep out_row/out_idx at their last values.
            done_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = lowest_set(above_mask);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the wide frame register is reset only because out_row must read 0 out of reset; pure datapath storage normally needs no reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q <= state_d;
      frame_q <= frame_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_EMIT);
  assign out_valid  = (state_q == ST_EMIT);
  assign out_row    = frame_q[idx_q*ROW_W +: ROW_W];
  assign out_idx    = idx_q;
  assign out_last   = (state_q == ST_EMIT) && is_last;
  assign frame_done = done_q;

endmodule
